// File: rtl/fpna_loader_pkg.sv
// fpna_loader_pkg: shared types, constants and the CRC-8 helper for the
// neuron-array bitstream loader.
package fpna_loader_pkg;

    // Loader FSM states; the top module maps these onto 3-bit constants.
    typedef enum logic [2:0] {
        LS_IDLE   = 3'd0,
        LS_FETCH  = 3'd1,
        LS_SHIFT  = 3'd2,
        LS_CHECK  = 3'd3,
        LS_FINISH = 3'd4,
        LS_DONE   = 3'd5,
        LS_ERR    = 3'd6
    } loader_state_e;

    localparam logic [7:0] CRC8_POLY         = 8'h07;
    localparam int         DEFAULT_CHAIN_LEN = 523;

    // CRC-8, MSB-first, no reflection, no final XOR: fold one whole byte.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/fpna_loader_crc8.sv
// fpna_loader_crc8: byte-wide CRC-8 accumulator with synchronous clear and
// update enable. Clear wins over enable.
module fpna_loader_crc8
    import fpna_loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    // Next CRC value: hold, clear for a new load, or fold in an accepted byte.
    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = 8'h00;
        end else if (en) begin
            crc_d = crc8_byte(crc_q, data);
        end
    end

    // CRC state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/fpna_bitstream_loader.sv
// fpna_bitstream_loader: accepts payload bytes on a valid/ready port and
// shifts them LSB-first into the neuron array's configuration chain, then
// pulses the array's neuron reset once the whole chain is loaded.
// Defining FPNA_LOADER_CRC_EN adds a CRC-8 trailer byte that must match the
// payload before the load is declared done.
module fpna_bitstream_loader
    import fpna_loader_pkg::*;
#(
    parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       config_en,
    output logic       bs_out,
    output logic       nn_reset,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [2:0] ST_IDLE   = LS_IDLE;
    localparam logic [2:0] ST_FETCH  = LS_FETCH;
    localparam logic [2:0] ST_SHIFT  = LS_SHIFT;
    localparam logic [2:0] ST_FINISH = LS_FINISH;
    localparam logic [2:0] ST_DONE   = LS_DONE;
`ifdef FPNA_LOADER_CRC_EN
    localparam logic [2:0] ST_CHECK  = LS_CHECK;
    localparam logic [2:0] ST_ERR    = LS_ERR;
`endif

    // Counter value during the cycle that shifts the final chain bit.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       bit_q,   bit_d;
    logic [7:0]       sreg_q,  sreg_d;
    logic             done_q,  done_d;
    logic             idle_like;

`ifdef FPNA_LOADER_CRC_EN
    logic             error_q, error_d;
    logic             trl_q,   trl_d;
    logic             crc_clr;
    logic             crc_en;
    logic [7:0]       crc_val;

    fpna_loader_crc8 u_crc8 (
        .clk   (clk),
        .reset (reset),
        .clr   (crc_clr),
        .en    (crc_en),
        .data  (in_data),
        .crc   (crc_val)
    );

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
`else
    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
`endif

    // FSM and datapath next-state: byte fetch, bit shifting, completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sreg_d  = sreg_q;
        done_d  = done_q;
`ifdef FPNA_LOADER_CRC_EN
        error_d = error_q;
        trl_d   = trl_q;
        crc_clr = 1'b0;
        crc_en  = 1'b0;
`endif
        if (idle_like) begin
            // A new load wipes all results of the previous one.
            if (start) begin
                state_d = ST_FETCH;
                cnt_d   = '0;
                bit_d   = 3'd0;
                done_d  = 1'b0;
`ifdef FPNA_LOADER_CRC_EN
                error_d = 1'b0;
                trl_d   = 1'b0;
                crc_clr = 1'b1;
`endif
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (in_valid) begin
                        sreg_d = in_data;
                        bit_d  = 3'd0;
`ifdef FPNA_LOADER_CRC_EN
                        if (trl_q) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_SHIFT;
                            crc_en  = 1'b1;
                        end
`else
                        state_d = ST_SHIFT;
`endif
                    end
                end
                ST_SHIFT: begin
                    sreg_d = {1'b0, sreg_q[7:1]};
                    cnt_d  = cnt_q + CNT_W'(1);
                    bit_d  = bit_q + 3'd1;
                    if (cnt_q == CNT_LAST) begin
`ifdef FPNA_LOADER_CRC_EN
                        state_d = ST_FETCH;
                        trl_d   = 1'b1;
`else
                        state_d = ST_FINISH;
`endif
                    end else if (bit_q == 3'd7) begin
                        state_d = ST_FETCH;
                    end
                end
`ifdef FPNA_LOADER_CRC_EN
                ST_CHECK: begin
                    // The trailer byte sits in the shift register.
                    if (sreg_q == crc_val) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
`endif
                ST_FINISH: begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Loader state registers; reset abandons any load in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            sreg_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
            done_q  <= done_d;
        end
    end

`ifdef FPNA_LOADER_CRC_EN
    // Trailer-phase flag and sticky CRC error.
    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
            trl_q   <= 1'b0;
        end else begin
            error_q <= error_d;
            trl_q   <= trl_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign in_ready  = (state_q == ST_FETCH);
    assign config_en = (state_q == ST_SHIFT);
    assign bs_out    = config_en & sreg_q[0];
    assign nn_reset  = (state_q == ST_FINISH);
    assign busy      = ~idle_like;
    assign done      = done_q;

endmodule

// File: tb/tb_fpna_bitstream_loader.sv
// Bench for fpna_bitstream_loader: a short-chain instance (A) for the
// directed scenarios and a default-length instance (B) for the full load.
// Expected chain bits are queued as stimulus is issued; monitors pop and
// compare them whenever config_en is high.
module tb_fpna_bitstream_loader;

`ifdef FPNA_LOADER_CRC_EN
    localparam int LA     = 72;
    localparam int NN_GAP = 3;
`else
    localparam int LA     = 12;
    localparam int NN_GAP = 1;
`endif
    localparam int LB    = 523;
    localparam int NB_B  = (LB + 7) / 8;
    localparam int CYC_B = NB_B + LB + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // ---------------- instance A ----------------
    logic       a_reset = 1'b1, a_start = 1'b0, a_in_valid = 1'b0;
    logic [7:0] a_in_data = 8'h00;
    logic       a_in_ready, a_config_en, a_bs_out, a_nn_reset, a_busy, a_done, a_error;

    fpna_bitstream_loader #(.CHAIN_LEN(LA)) u_dut_a (
        .clk       (clk),
        .reset     (a_reset),
        .start     (a_start),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .config_en (a_config_en),
        .bs_out    (a_bs_out),
        .nn_reset  (a_nn_reset),
        .busy      (a_busy),
        .done      (a_done),
        .error     (a_error)
    );

    // ---------------- instance B ----------------
    logic       b_reset = 1'b1, b_start = 1'b0, b_in_valid = 1'b0;
    logic [7:0] b_in_data = 8'h00;
    logic       b_in_ready, b_config_en, b_bs_out, b_nn_reset, b_busy, b_done, b_error;

    fpna_bitstream_loader u_dut_b (
        .clk       (clk),
        .reset     (b_reset),
        .start     (b_start),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .config_en (b_config_en),
        .bs_out    (b_bs_out),
        .nn_reset  (b_nn_reset),
        .busy      (b_busy),
        .done      (b_done),
        .error     (b_error)
    );

    // Scoreboards and monitor statistics.
    logic exp_a[$];
    logic exp_b[$];
    logic exp_b_all [LB];
    int   a_en_cnt = 0, a_nn_cnt = 0, a_hs = 0, a_cyc = 0, a_last_en = 0;
    logic a_prev_nn = 1'b0;
    int   b_en_cnt = 0, b_nn_cnt = 0, b_busy_cnt = 0;
    logic [LB-1:0] chain_b = '0;

    // Monitor A: pop expected bits on every shift cycle, check pulse timing.
    always @(negedge clk) begin
        chk("a_bs_out_outside_shift", 32'(a_bs_out & ~a_config_en), 0);
        if (a_in_valid && a_in_ready) a_hs++;
        if (a_config_en) begin
            a_en_cnt++;
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_extra_shift: got bit %0d expected no shift", a_bs_out);
            end else begin
                chk("a_bs_out", a_bs_out, exp_a.pop_front());
            end
        end
        if (a_nn_reset) begin
            a_nn_cnt++;
            chk("a_nn_gap", a_cyc - a_last_en, NN_GAP);
        end
        if (a_prev_nn) begin
            chk("a_done_after_nn", a_done, 1);
            chk("a_nn_one_cycle", a_nn_reset, 0);
        end
        a_prev_nn = a_nn_reset;
        if (a_config_en) a_last_en = a_cyc;
        a_cyc++;
    end

    // Monitor B: scoreboard plus cycle accounting for the full-length load.
    always @(negedge clk) begin
        if (b_busy) b_busy_cnt++;
        if (b_nn_reset) b_nn_cnt++;
        if (b_config_en) begin
            b_en_cnt++;
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_extra_shift: got bit %0d expected no shift", b_bs_out);
            end else begin
                chk("b_bs_out", b_bs_out, exp_b.pop_front());
            end
        end
    end

    // Model of the array's configuration chain fed by instance B.
    always @(posedge clk) begin
        if (b_config_en) chain_b <= {chain_b[LB-2:0], b_bs_out};
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) exp_a.push_back(b[i]);
    endtask

    task automatic a_pulse_start();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic a_send(input logic [7:0] b);
        int n = 0;
        a_in_data  = b;
        a_in_valid = 1'b1;
        while (!a_in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("a_send_ready", a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
    endtask

    task automatic a_wait_end(input int budget);
        int n = 0;
        while (!(a_done || a_error) && n < budget) begin
            tick();
            n++;
        end
        chk("a_end_reached", 32'(a_done | a_error), 1);
        tick();
        tick();
    endtask

    task automatic b_send(input logic [7:0] b);
        int n = 0;
        b_in_data  = b;
        b_in_valid = 1'b1;
        while (!b_in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("b_send_ready", b_in_ready, 1);
        tick();
        b_in_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [11:0] exp12;
        int base_en, base_nn, base_hs, n, mism;
        logic [7:0] bb;
        logic [7:0] ascii [9];
        exp12 = 12'b0011_1010_0101;
        ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        repeat (3) @(posedge clk);
        #1;
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Reset state.
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_config_en", a_config_en, 0);
        chk("rst_bs_out", a_bs_out, 0);
        chk("rst_nn_reset", a_nn_reset, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_error", a_error, 0);

`ifndef FPNA_LOADER_CRC_EN
        // Basic load: 0xA5, 0x03 into a 12-bit chain.
        base_en = a_en_cnt; base_nn = a_nn_cnt; base_hs = a_hs;
        for (int i = 0; i < 12; i++) exp_a.push_back(exp12[i]);
        a_pulse_start();
        chk("t1_busy", a_busy, 1);
        chk("t1_in_ready", a_in_ready, 1);
        a_send(8'hA5);
        a_send(8'h03);
        a_wait_end(200);
        chk("t1_done", a_done, 1);
        chk("t1_busy_after", a_busy, 0);
        chk("t1_en_cycles", a_en_cnt - base_en, 12);
        chk("t1_nn_pulses", a_nn_cnt - base_nn, 1);
        chk("t1_bytes", a_hs - base_hs, 2);
        chk("t1_queue_left", exp_a.size(), 0);

        // Host stalls 5 cycles between bytes.
        base_en = a_en_cnt; base_nn = a_nn_cnt;
        for (int i = 0; i < 12; i++) exp_a.push_back(exp12[i]);
        a_pulse_start();
        chk("t2_done_cleared", a_done, 0);
        a_send(8'hA5);
        repeat (8) tick();
        for (int i = 0; i < 5; i++) begin
            chk("t2_stall_config_en", a_config_en, 0);
            chk("t2_stall_in_ready", a_in_ready, 1);
            tick();
        end
        a_send(8'h03);
        a_wait_end(200);
        chk("t2_done", a_done, 1);
        chk("t2_en_cycles", a_en_cnt - base_en, 12);
        chk("t2_nn_pulses", a_nn_cnt - base_nn, 1);
        chk("t2_queue_left", exp_a.size(), 0);

        // start pulsed in SHIFT and in_valid held high throughout.
        base_en = a_en_cnt; base_nn = a_nn_cnt; base_hs = a_hs;
        for (int i = 0; i < 12; i++) exp_a.push_back(exp12[i]);
        a_pulse_start();
        a_in_data  = 8'hA5;
        a_in_valid = 1'b1;
        tick();
        a_in_data = 8'h03;
        tick();
        tick();
        chk("t3_in_shift", a_config_en, 1);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("t3_start_ignored_busy", a_busy, 1);
        chk("t3_start_ignored_en", a_config_en, 1);
        n = 0;
        while (!a_in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("t3_second_fetch", a_in_ready, 1);
        tick();
        a_in_data = 8'hFF;
        n = 0;
        while (!a_done && n < 200) begin
            tick();
            n++;
        end
        repeat (5) tick();
        a_in_valid = 1'b0;
        chk("t3_done", a_done, 1);
        chk("t3_bytes", a_hs - base_hs, 2);
        chk("t3_en_cycles", a_en_cnt - base_en, 12);
        chk("t3_nn_pulses", a_nn_cnt - base_nn, 1);
        chk("t3_queue_left", exp_a.size(), 0);
`else
        // CRC build: "123456789" with the correct trailer 0xF4.
        base_en = a_en_cnt; base_nn = a_nn_cnt; base_hs = a_hs;
        for (int i = 0; i < 9; i++) push_a(ascii[i], 8);
        a_pulse_start();
        for (int i = 0; i < 9; i++) a_send(ascii[i]);
        a_send(8'hF4);
        a_wait_end(2000);
        chk("c1_done", a_done, 1);
        chk("c1_error", a_error, 0);
        chk("c1_en_cycles", a_en_cnt - base_en, 72);
        chk("c1_nn_pulses", a_nn_cnt - base_nn, 1);
        chk("c1_bytes", a_hs - base_hs, 10);
        chk("c1_queue_left", exp_a.size(), 0);

        // Same payload, wrong trailer 0xF5.
        base_en = a_en_cnt; base_nn = a_nn_cnt;
        for (int i = 0; i < 9; i++) push_a(ascii[i], 8);
        a_pulse_start();
        for (int i = 0; i < 9; i++) a_send(ascii[i]);
        a_send(8'hF5);
        a_wait_end(2000);
        chk("c2_error", a_error, 1);
        chk("c2_done", a_done, 0);
        chk("c2_busy", a_busy, 0);
        chk("c2_en_cycles", a_en_cnt - base_en, 72);
        chk("c2_nn_pulses", a_nn_cnt - base_nn, 0);
        chk("c2_queue_left", exp_a.size(), 0);

        // Restart from ERR clears the error.
        a_pulse_start();
        chk("c3_error_cleared", a_error, 0);
        chk("c3_busy", a_busy, 1);
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
`endif

        // Reset asserted during the 4th SHIFT cycle.
        base_en = a_en_cnt; base_nn = a_nn_cnt;
        push_a(8'hA5, 4);
        a_pulse_start();
        a_send(8'hA5);
        tick();
        tick();
        tick();
        chk("t4_still_shifting", a_config_en, 1);
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        chk("t4_config_en", a_config_en, 0);
        chk("t4_busy", a_busy, 0);
        chk("t4_done", a_done, 0);
        chk("t4_nn_reset", a_nn_reset, 0);
        repeat (20) tick();
        chk("t4_nn_pulses", a_nn_cnt - base_nn, 0);
        chk("t4_en_cycles", a_en_cnt - base_en, 4);
        chk("t4_queue_left", exp_a.size(), 0);

`ifndef FPNA_LOADER_CRC_EN
        // Reload after the aborted load.
        base_nn = a_nn_cnt;
        for (int i = 0; i < 12; i++) exp_a.push_back(exp12[i]);
        a_pulse_start();
        a_send(8'hA5);
        a_send(8'h03);
        a_wait_end(200);
        chk("t5_done", a_done, 1);
        chk("t5_nn_pulses", a_nn_cnt - base_nn, 1);
        chk("t5_queue_left", exp_a.size(), 0);

        // Full default-length chain: 66 bytes, last one with 3 valid bits.
        n = 0;
        for (int i = 0; i < NB_B; i++) begin
            bb = (i == NB_B - 1) ? 8'hFA : 8'(i * 29 + 7);
            for (int k = 0; k < 8 && n < LB; k++) begin
                exp_b.push_back(bb[k]);
                exp_b_all[n] = bb[k];
                n++;
            end
        end
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < NB_B; i++) begin
            bb = (i == NB_B - 1) ? 8'hFA : 8'(i * 29 + 7);
            b_send(bb);
        end
        n = 0;
        while (!b_done && n < 100) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk("b_done", b_done, 1);
        chk("b_busy_cycles", b_busy_cnt, CYC_B);
        chk("b_en_cycles", b_en_cnt, LB);
        chk("b_nn_pulses", b_nn_cnt, 1);
        chk("b_queue_left", exp_b.size(), 0);
        mism = 0;
        for (int k = 0; k < LB; k++) begin
            if (chain_b[LB-1-k] !== exp_b_all[k]) mism++;
        end
        chk("b_readback_mismatches", mism, 0);
        chk("b_last_bit_nearest_input", chain_b[0], exp_b_all[LB-1]);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1);
    end

endmodule

// File: doc/fpna_bitstream_loader.md
# fpna_bitstream_loader

- Host-side configuration front end for the neuron array; sits directly upstream of the array's serial configuration chain.
- Accepts payload bytes over a valid/ready byte port and serializes them LSB-first into the chain's `bs_in`, holding `config_en` high only while bits move.
- Stops after exactly `CHAIN_LEN` bits. On success, issues a one-cycle neuron-reset pulse so potentials restart from the configured state.

## Interface
Parameters:
- `CHAIN_LEN`, default 523: total chain bits (clock box 48 + 25 cells × 19).
- `CNT_W`, default `$clog2(CHAIN_LEN+1)`: bit-counter width.

Ports:
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin a load. Sampled only in IDLE, DONE or ERR.
- `in_data` input 8: payload byte.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: loader accepts a byte this cycle.
- `config_en` output 1: chain shift enable.
- `bs_out` output 1: serial bit to the chain's `bs_in`.
- `nn_reset` output 1: one-cycle pulse to the array's `reset_nn`.
- `busy` output 1: state is not IDLE, DONE or ERR.
- `done` output 1: sticky; load completed successfully.
- `error` output 1: sticky; CRC mismatch (CRC build only).

## Operation
- Reset values: all outputs 0; state IDLE; bit counter 0; shift register 0; CRC register 0x00.

States:
- IDLE / DONE / ERR: `start`=1 → FETCH. Clears `done`, `error`, the bit counter and the CRC.
- FETCH: `in_ready`=1. On `in_valid`, latch the byte into the shift register → SHIFT.
- SHIFT, per cycle:
  - `config_en`=1, `bs_out`=sreg[0], sreg shifts right, counter+1.
  - Leave SHIFT after 8 bits, or earlier when the counter reaches `CHAIN_LEN`.
  - If the counter is below `CHAIN_LEN` → FETCH. Otherwise → CHECK (CRC build) or FINISH.
- Final byte: carries `CHAIN_LEN mod 8` valid bits in its LSBs; upper bits are ignored. Byte count is ceil(`CHAIN_LEN`/8).
- Bit order: first bit shifted ends deepest in the chain.
- FINISH: `nn_reset`=1 for one cycle, `done`←1 → DONE.
- `start` while `busy`: ignored.
- `in_valid` outside FETCH: ignored; the byte is not consumed.
- Reset mid-load: state returns to IDLE on the next edge and `config_en` drops. The chain is left partially loaded; the host must reload.
- `config_en` is 0 in every state except SHIFT. `bs_out` is 0 outside SHIFT.

## Timing
- Byte handshake completes on the edge where `in_valid && in_ready`. SHIFT begins the next cycle.
- Per full byte: 1 FETCH cycle + 8 SHIFT cycles, with zero host stall.
- Minimum load time: ceil(`CHAIN_LEN`/8) + `CHAIN_LEN` cycles, plus 1 (FINISH). The CRC build adds 1 FETCH + 1 CHECK cycle.
- `nn_reset` rises the cycle after the last `config_en`=1 (+2 cycles with CRC). `done` rises on the same edge that drops `nn_reset`.
- `in_ready` is combinational from state only; there is no path from `in_valid`.

## Configuration
- Macro `FPNA_LOADER_CRC_EN`.
- Defined:
  - The CRC covers every accepted payload byte, whole, including ignored padding bits.
  - Algorithm: CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR).
  - After the last SHIFT → FETCH one extra byte (the CRC) → CHECK.
  - Match → FINISH. Mismatch → ERR: `error`←1, no `nn_reset`.
- Undefined: no CRC logic, no trailer byte, no CHECK/ERR states; `error` is tied to 0.

## Structure
- Package `fpna_loader_pkg`: state enum (IDLE, FETCH, SHIFT, CHECK, FINISH, DONE, ERR); `CRC8_POLY`=8'h07; `DEFAULT_CHAIN_LEN`=523; function `crc8_byte(crc, data)`.
- Sub-module `fpna_loader_crc8`: byte-wide CRC update register with clear and enable. Instantiated only under the macro.

## Test plan
- `CHAIN_LEN`=12, bytes 0xA5, 0x03 → `bs_out` while `config_en`=1: 1,0,1,0,0,1,0,1,1,1,0,0. `config_en` is high for exactly 12 cycles; `nn_reset` pulses once; `done`=1.
- Same load with `in_valid` stalled 5 cycles between bytes → `config_en` low during the stall; `bs_out` sequence unchanged.
- `start` pulsed during SHIFT, and `in_valid` held high in SHIFT → ignored; exactly 2 bytes consumed.
- `reset` asserted on the 4th SHIFT cycle → next cycle `config_en`=0, `busy`=0, `done`=0, `nn_reset` never pulses.
- CRC build, `CHAIN_LEN`=72, payload ASCII "123456789", trailer 0xF4 → `done`=1. Trailer 0xF5 → `error`=1, `done`=0, no `nn_reset`.
- Full default `CHAIN_LEN`=523: 66 bytes (no CRC) → completion in 66+523+1 = 590 cycles with zero stall. The 523rd bit lands in the clock box; readback via the chain's `bs_out` matches.
